// File: rtl/mmu_scheduler.sv
// mmu_scheduler: shares one 2x2 systolic multiply unit between two requesters.
// Requesters are picked round-robin. Each job holds the array in reset for one
// LOAD cycle, then runs it until done or until the timeout counter expires. The
// tagged result is then offered on a single response handshake.
module mmu_scheduler #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_c,
  output logic        rsp_err,
  output logic        mmu_rst,
  output logic [31:0] mmu_a,
  output logic [31:0] mmu_b,
  input  logic [31:0] mmu_c,
  input  logic        mmu_done,
  output logic        busy
);

  // Reject parameter sets where the counter cannot reach TIMEOUT-1.
  if (TIMEOUT < 1 || TIMEOUT >= (2 ** CNT_W)) begin : g_bad_timeout
    $error("mmu_scheduler: TIMEOUT must be >= 1 and < 2**CNT_W");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state_reg;
  logic             last_grant_reg;
  logic [CNT_W-1:0] cnt_reg;

  logic [1:0] req_valid;
  logic [1:0] req_ready;
  logic       grant_any;
  logic       grant_id;

  assign req_valid = {req1_valid, req0_valid};

  // Single requester wins outright; on a tie the one not served last wins.
  always_comb begin
    grant_any = |req_valid;
    grant_id  = (&req_valid) ? ~last_grant_reg : req_valid[1];
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_ready
    assign req_ready[gi] = (state_reg == IDLE) && grant_any && (grant_id == (gi == 1));
  end

  assign req0_ready = req_ready[0];
  assign req1_ready = req_ready[1];

  // Job sequencer: accept, hold array in reset one cycle, run, then respond.
  // mmu_rst, rsp_valid and busy are kept as flops next to the state so they
  // leave the block glitch-free.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      last_grant_reg <= 1'b1;
      cnt_reg        <= '0;
      mmu_a          <= '0;
      mmu_b          <= '0;
      rsp_c          <= '0;
      rsp_id         <= 1'b0;
      rsp_err        <= 1'b0;
      mmu_rst        <= 1'b1;
      rsp_valid      <= 1'b0;
      busy           <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (grant_any) begin
            mmu_a          <= grant_id ? req1_a : req0_a;
            mmu_b          <= grant_id ? req1_b : req0_b;
            rsp_id         <= grant_id;
            last_grant_reg <= grant_id;
            busy           <= 1'b1;
            state_reg      <= LOAD;
          end
        end
        LOAD: begin
          cnt_reg   <= '0;
          mmu_rst   <= 1'b0;
          state_reg <= RUN;
        end
        RUN: begin
          if (mmu_done) begin
            rsp_c     <= mmu_c;
            rsp_err   <= 1'b0;
            mmu_rst   <= 1'b1;
            rsp_valid <= 1'b1;
            state_reg <= RESP;
          end else if (cnt_reg == CNT_LAST) begin
            rsp_c     <= '0;
            rsp_err   <= 1'b1;
            mmu_rst   <= 1'b1;
            rsp_valid <= 1'b1;
            state_reg <= RESP;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: begin
          mmu_rst   <= 1'b1;
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmu_scheduler.sv
// tb_mmu_scheduler: directed scenarios plus a randomized phase for the
// mmu_scheduler. A behavioural mmu model and a transaction-level reference model
// run alongside the design.
module tb_mmu_scheduler;

  localparam int TIMEOUT = 15;
  localparam int CNT_W   = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic        rsp_valid, rsp_id, rsp_err;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_c;
  logic        mmu_rst;
  logic [31:0] mmu_a, mmu_b, mmu_c;
  logic        mmu_done;
  logic        busy;

  always #5 clk = ~clk;

  mmu_scheduler #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_c(rsp_c),
    .rsp_err(rsp_err), .mmu_rst(mmu_rst), .mmu_a(mmu_a), .mmu_b(mmu_b),
    .mmu_c(mmu_c), .mmu_done(mmu_done), .busy(busy)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // 2x2 row-major matrix product, 8-bit wrapping elements.
  function automatic logic [31:0] matmul(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] c;
    logic [7:0]  s;
    c = '0;
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 2; j++) begin
        s = '0;
        for (int k = 0; k < 2; k++)
          s = s + a[8*(2*i+k) +: 8] * b[8*(2*k+j) +: 8];
        c[8*(2*i+j) +: 8] = s;
      end
    end
    return c;
  endfunction

  // Behavioural mmu: done after 'lat' cycles out of reset; lat==0 never finishes.
  int   lat = 0;
  int   run_cnt = 0;
  logic done_force = 1'b0;
  always @(posedge clk) run_cnt <= mmu_rst ? 0 : run_cnt + 1;
  assign mmu_c    = matmul(mmu_a, mmu_b);
  assign mmu_done = done_force || (!mmu_rst && lat >= 1 && run_cnt == lat - 1);

  // Stimulus control shared by driver and monitor.
  int lat_fixed = 1;
  bit rand_lat  = 1'b0;
  bit rand_mode = 1'b0;
  int jobs0 = 0, jobs1 = 0;
  bit hs0 = 1'b0, hs1 = 1'b0;

  // Observed transaction logs.
  int          acc_cyc[$];
  bit          acc_id[$];
  int          rise_cyc[$];
  logic [31:0] rise_c[$];
  bit          rise_id[$];
  bit          rise_err[$];

  // Reference model state: one outstanding job described by its timeline.
  int          cyc = 0;
  bit          m_busy = 1'b0, m_last = 1'b1, m_id = 1'b0, m_err = 1'b0;
  int          m_acc = 0, m_resp_at = 0, eff = 0;
  logic [31:0] m_a = '0, m_b = '0, m_c = '0, sel_a, sel_b;
  bit          exp_valid, exp_mmu_rst, g_any, g_id, prev_valid = 1'b0;

  // Monitor: compare the design against the model every cycle at the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      exp_valid   = m_busy && (cyc >= m_resp_at);
      exp_mmu_rst = !(m_busy && cyc >= m_acc + 2 && cyc < m_resp_at);
      g_any       = req0_valid || req1_valid;
      g_id        = (req0_valid && req1_valid) ? !m_last : req1_valid;
      check("busy", 32'(busy), 32'(m_busy));
      check("rsp_valid", 32'(rsp_valid), 32'(exp_valid));
      check("mmu_rst", 32'(mmu_rst), 32'(exp_mmu_rst));
      check("req0_ready", 32'(req0_ready), 32'(!m_busy && g_any && !g_id));
      check("req1_ready", 32'(req1_ready), 32'(!m_busy && g_any && g_id));
      check("mmu_a", mmu_a, m_a);
      check("mmu_b", mmu_b, m_b);
      if (exp_valid) begin
        check("rsp_id", 32'(rsp_id), 32'(m_id));
        check("rsp_c", rsp_c, m_c);
        check("rsp_err", 32'(rsp_err), 32'(m_err));
      end

      hs0 = req0_valid && req0_ready && !rst;
      hs1 = req1_valid && req1_ready && !rst;
      if (hs0 || hs1) begin
        acc_cyc.push_back(cyc);
        acc_id.push_back(hs1);
      end
      if (rsp_valid && !prev_valid) begin
        rise_cyc.push_back(cyc);
        rise_c.push_back(rsp_c);
        rise_id.push_back(rsp_id);
        rise_err.push_back(rsp_err);
        $display("rsp cyc=%0d id=%0d c=%h err=%0d", cyc, rsp_id, rsp_c, rsp_err);
      end
      prev_valid = rsp_valid;

      if (rst) begin
        m_busy = 1'b0;
        m_last = 1'b1;
        m_a    = '0;
        m_b    = '0;
      end else if (!m_busy && g_any) begin
        lat       = rand_lat ? int'($urandom_range(0, 17)) : lat_fixed;
        m_err     = !(lat >= 1 && lat <= TIMEOUT);
        eff       = m_err ? TIMEOUT : lat;
        sel_a     = g_id ? req1_a : req0_a;
        sel_b     = g_id ? req1_b : req0_b;
        m_a       = sel_a;
        m_b       = sel_b;
        m_c       = m_err ? 32'h0 : matmul(sel_a, sel_b);
        m_id      = g_id;
        m_last    = g_id;
        m_acc     = cyc;
        m_resp_at = cyc + 2 + eff;
        m_busy    = 1'b1;
      end else if (exp_valid && rsp_ready) begin
        m_busy = 1'b0;
      end
    end
  end

  // One driver cycle: inputs change 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
    if (hs0) begin
      if (jobs0 > 0) jobs0--;
      req0_a = $urandom; req0_b = $urandom;
    end
    if (hs1) begin
      if (jobs1 > 0) jobs1--;
      req1_a = $urandom; req1_b = $urandom;
    end
    if (rand_mode) begin
      if (hs0 || !req0_valid) begin
        req0_valid = ($urandom_range(0, 2) == 0);
        req0_a = $urandom; req0_b = $urandom;
      end else if ($urandom_range(0, 7) == 0) begin
        req0_valid = 1'b0;
      end
      if (hs1 || !req1_valid) begin
        req1_valid = ($urandom_range(0, 2) == 0);
        req1_a = $urandom; req1_b = $urandom;
      end else if ($urandom_range(0, 7) == 0) begin
        req1_valid = 1'b0;
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
    end else begin
      req0_valid = (jobs0 > 0);
      req1_valid = (jobs1 > 0);
    end
  endtask

  task automatic drain(input string tag, input int maxc);
    int n = 0;
    step();
    while ((jobs0 > 0 || jobs1 > 0 || busy) && n < maxc) begin
      step();
      n++;
    end
    check(tag, 32'(busy || jobs0 > 0 || jobs1 > 0), 32'd0);
  endtask

  task automatic clear_logs();
    acc_cyc.delete(); acc_id.delete();
    rise_cyc.delete(); rise_c.delete(); rise_id.delete(); rise_err.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
  endtask

  initial begin
    logic [31:0] e_a, e_b;
    int n;

    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    step();
    check("reset_rsp_c", rsp_c, 32'h0);
    check("reset_rsp_id", 32'(rsp_id), 32'd0);
    check("reset_rsp_err", 32'(rsp_err), 32'd0);
    check("reset_mmu_a", mmu_a, 32'h0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_mmu_rst", 32'(mmu_rst), 32'd1);

    // Single job with 3-cycle mmu.
    clear_logs();
    lat_fixed = 3;
    req0_a = 32'h04030201;
    req0_b = 32'h08070605;
    jobs0 = 1;
    drain("single_drain", 40);
    check("single_count", 32'(rise_cyc.size()), 32'd1);
    if (rise_cyc.size() > 0 && acc_cyc.size() > 0) begin
      check("single_c", rise_c[0], 32'h322B1613);
      check("single_id", 32'(rise_id[0]), 32'd0);
      check("single_err", 32'(rise_err[0]), 32'd0);
      check("single_latency", 32'(rise_cyc[0] - acc_cyc[0]), 32'd5);
    end

    // Tie after reset, then alternation with both valids held.
    do_reset();
    clear_logs();
    lat_fixed = 1;
    jobs0 = 4;
    jobs1 = 4;
    drain("tie_drain", 120);
    check("tie_count", 32'(acc_id.size()), 32'd8);
    for (int k = 0; k < acc_id.size() && k < rise_id.size(); k++) begin
      check("tie_acc_id", 32'(acc_id[k]), 32'(k % 2));
      check("tie_rsp_id", 32'(rise_id[k]), 32'(k % 2));
    end

    // Single persistent requester, 1-cycle mmu: one accept every 4 cycles.
    clear_logs();
    jobs1 = 4;
    drain("solo_drain", 60);
    check("solo_count", 32'(acc_cyc.size()), 32'd4);
    for (int k = 1; k < acc_cyc.size(); k++) begin
      check("solo_period", 32'(acc_cyc[k] - acc_cyc[k-1]), 32'd4);
      check("solo_id", 32'(acc_id[k]), 32'd1);
    end

    // Timeout with no done, then done exactly in the last RUN cycle.
    clear_logs();
    lat_fixed = 0;
    jobs0 = 1;
    drain("tmo_drain", 60);
    lat_fixed = TIMEOUT;
    e_a = req1_a;
    e_b = req1_b;
    jobs1 = 1;
    drain("late_drain", 60);
    check("tmo_count", 32'(rise_cyc.size()), 32'd2);
    if (rise_cyc.size() > 1 && acc_cyc.size() > 1) begin
      check("tmo_err", 32'(rise_err[0]), 32'd1);
      check("tmo_c", rise_c[0], 32'h0);
      check("tmo_latency", 32'(rise_cyc[0] - acc_cyc[0]), 32'd17);
      check("late_err", 32'(rise_err[1]), 32'd0);
      check("late_c", rise_c[1], matmul(e_a, e_b));
      check("late_latency", 32'(rise_cyc[1] - acc_cyc[1]), 32'd17);
    end

    // Backpressure: response held for 10 cycles with other requests pending.
    clear_logs();
    lat_fixed = 2;
    rsp_ready = 1'b0;
    e_a = req0_a;
    e_b = req0_b;
    jobs0 = 1;
    n = 0;
    while (!rsp_valid && n < 30) begin
      step();
      n++;
    end
    check("bp_reached", 32'(rsp_valid), 32'd1);
    jobs0 = 1;
    jobs1 = 1;
    repeat (10) begin
      step();
      check("bp_c", rsp_c, matmul(e_a, e_b));
      check("bp_id", 32'(rsp_id), 32'd0);
      check("bp_err", 32'(rsp_err), 32'd0);
      check("bp_readies", 32'({req0_ready, req1_ready}), 32'd0);
      check("bp_mmu_rst", 32'(mmu_rst), 32'd1);
      check("bp_busy", 32'(busy), 32'd1);
    end
    rsp_ready = 1'b1;
    step();
    check("bp_release_busy", 32'(busy), 32'd0);
    check("bp_release_valid", 32'(rsp_valid), 32'd0);
    check("bp_release_grant", 32'(req0_ready || req1_ready), 32'd1);
    drain("bp_drain", 80);

    // Reset while RUN is in progress: the job vanishes.
    clear_logs();
    lat_fixed = 10;
    jobs0 = 1;
    n = 0;
    while (mmu_rst && n < 20) begin
      step();
      n++;
    end
    check("mid_run_reached", 32'(mmu_rst), 32'd0);
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_valid", 32'(rsp_valid), 32'd0);
    check("mid_rst_mmu_rst", 32'(mmu_rst), 32'd1);
    repeat (20) step();
    check("mid_rst_no_rsp", 32'(rise_cyc.size()), 32'd0);

    // Spurious done while idle.
    done_force = 1'b1;
    step();
    done_force = 1'b0;
    repeat (5) step();
    check("stale_done_no_rsp", 32'(rise_cyc.size()), 32'd0);
    check("stale_done_busy", 32'(busy), 32'd0);

    // Randomized traffic, latencies, drops and backpressure.
    clear_logs();
    rand_lat = 1'b1;
    rand_mode = 1'b1;
    repeat (600) step();
    rand_mode = 1'b0;
    rsp_ready = 1'b1;
    jobs0 = 0;
    jobs1 = 0;
    drain("rand_drain", 60);
    check("rand_rsp_per_accept", 32'(rise_cyc.size()), 32'(acc_cyc.size()));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mmu_scheduler.md
# mmu_scheduler

Round-robin scheduler that shares one 2x2 `mmu` systolic multiply unit between two independent requesters. Each requester submits a packed A/B operand pair over a valid/ready handshake. The block sequences the `mmu` reset/run window and waits for `done`, with a timeout guard. It returns the 32-bit C result, tagged with the requester id, over a single response handshake. It sits between the host-facing load/unload logic and the `mmu` instance, replacing the one-shot start pulse with a reusable, back-to-back job flow.

## Interface
- `TIMEOUT`, 15: maximum RUN cycles before a job is aborted; must be ≥1 and < 2^`CNT_W`.
- `CNT_W`, 4: width of the RUN cycle counter.

- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req0_valid`  in  1  requester 0 has a job.
- `req0_ready`  out  1  requester 0 job accepted this cycle when valid is also high.
- `req0_a`, `req0_b`  in  32  requester 0 operands, packed as `mmu` A_flat/B_flat (element i at bits [8i+7:8i]).
- `req1_valid`, `req1_ready`, `req1_a`, `req1_b`: same as above, for requester 1.
- `rsp_valid`  out  1  response available.
- `rsp_ready`  in  1  consumer accepts response.
- `rsp_id`  out  1  requester that owns the response.
- `rsp_c`  out  32  captured `mmu` C_flat; 0 on error.
- `rsp_err`  out  1  job timed out.
- `mmu_rst`  out  1  drives `mmu` rst; high holds the array cleared.
- `mmu_a`, `mmu_b`  out  32  registered operands to `mmu`.
- `mmu_c`  in  32  `mmu` C_flat.
- `mmu_done`  in  1  `mmu` completion.
- `busy`  out  1  high whenever state ≠ IDLE.

## Operation
- States: IDLE, LOAD, RUN, RESP.
- IDLE
  - Grant is combinational.
  - If exactly one `reqN_valid` is high, that requester is granted.
  - If both are high, grant the requester ≠ `last_grant`.
  - `reqN_ready` = (state==IDLE) && (grant==N). The non-granted ready stays 0.
  - On handshake: capture `reqN_a`→`mmu_a`, `reqN_b`→`mmu_b`, N→`rsp_id` and `last_grant`, then go to LOAD.
- LOAD
  - One cycle with `mmu_rst`=1 so operands are stable before the array leaves reset.
  - Clear `cnt`, go to RUN.
- RUN
  - `mmu_rst`=0.
  - If `mmu_done`: `rsp_c`←`mmu_c`, `rsp_err`←0, go to RESP.
  - Else if `cnt`==`TIMEOUT`-1: `rsp_c`←0, `rsp_err`←1, go to RESP.
  - Else `cnt`++.
  - If done and timeout coincide, done wins.
- RESP
  - `mmu_rst`=1, `rsp_valid`=1.
  - `rsp_id`/`rsp_c`/`rsp_err` are held stable until `rsp_valid`&&`rsp_ready`, then go to IDLE.
- `mmu_rst` = (state ≠ RUN). `rsp_valid` = (state==RESP).
- `mmu_done` is ignored outside RUN. A stale done never produces a response.
- Requester valids need not be held by the block. A requester may drop valid before grant without error.

## Timing
- Reset values:
  - State IDLE, `last_grant`=1 (requester 0 wins the first tie), `cnt`=0.
  - `mmu_a`/`mmu_b`/`rsp_c`=0, `rsp_id`=0, `rsp_err`=0.
  - `rsp_valid`=0, `mmu_rst`=1, `busy`=0, both `reqN_ready`=0 unless valid is asserted in IDLE.
- Request accepted at cycle T:
  - LOAD at T+1.
  - RUN from T+2.
  - If `mmu_done` is seen at cycle D ≥ T+2, `rsp_valid` rises at D+1.
- Timeout: accepted at T, no done → RUN spans T+2..T+1+`TIMEOUT`, and RESP (`rsp_err`=1) starts at T+2+`TIMEOUT`.
- Back-to-back: response handshake at R → IDLE at R+1. A pending request is accepted at R+1.
- Minimum job period with a 1-cycle `mmu`: 4 cycles (IDLE, LOAD, RUN, RESP).
- Backpressure in RESP is unbounded. Both readies stay 0 and `mmu_rst` stays 1 throughout.
- `rst` mid-job, in any state:
  - Next cycle is the reset state.
  - The job is dropped and no response is issued.
  - `mmu_rst`=1.

## Test plan
- Single job, behavioural `mmu` (3-cycle latency): `req0_a`=0x04030201, `req0_b`=0x08070605 accepted at T → `mmu_rst` low T+2..T+4, `rsp_valid` at T+5 with `rsp_c`=0x322B1613, `rsp_id`=0, `rsp_err`=0.
- Tie after reset: both valids high at the same cycle → `req0_ready` first, responses in order `rsp_id` 0 then 1. Holding both valids high → ids alternate 0,1,0,1 for 8 jobs.
- Single persistent requester: only `req1_valid` high for 4 jobs → all granted to requester 1 back-to-back, one accept every 4 cycles with a 1-cycle `mmu`.
- Timeout: model never asserts done, `TIMEOUT`=15, accepted at T → `rsp_valid` at T+17, `rsp_err`=1, `rsp_c`=0. Separately, done in the 15th RUN cycle → `rsp_err`=0 with valid C.
- Backpressure: `rsp_ready` low for 10 cycles in RESP → `rsp_c`/`rsp_id`/`rsp_err` constant, both readies 0, `mmu_rst`=1, `busy`=1. Raising `rsp_ready` → IDLE next cycle.
- Reset mid-RUN, plus a spurious `mmu_done` pulse in IDLE:
  - Reset: next cycle `rsp_valid`=0, `mmu_rst`=1, `busy`=0, and no response is ever emitted for the aborted job.
  - Spurious done in IDLE: no response and no state change.
